// File: rtl/mailbox_pkg.sv
// mailbox_pkg: shared types and constants for the tohost/fromhost mailbox.
//   mbox_state_e       - mailbox protocol state
//   MBOX_TOHOST_ADDR   - default tohost word address
//   MBOX_FROMHOST_ADDR - default fromhost word address
//   MBOX_TIMEOUT_RESP  - response value substituted when the host never answers
//   mbox_merge()       - byte-enable merge of a store into a 64-bit word
package mailbox_pkg;

  typedef enum logic [1:0] {
    MBOX_IDLE    = 2'd0,
    MBOX_PENDING = 2'd1,
    MBOX_RESPOND = 2'd2,
    MBOX_DONE    = 2'd3
  } mbox_state_e;

  localparam logic [31:0] MBOX_TOHOST_ADDR   = 32'h8000_1000;
  localparam logic [31:0] MBOX_FROMHOST_ADDR = 32'h8000_1040;
  localparam logic [63:0] MBOX_TIMEOUT_RESP  = 64'hFFFF_FFFF_FFFF_FFFF;

  // Enabled bytes come from the store, the rest keep the old word.
  function automatic logic [63:0] mbox_merge(input logic [63:0] old_w,
                                             input logic [63:0] data,
                                             input logic [7:0]  mask);
    logic [63:0] res;
    res = old_w;
    for (int b = 0; b < 8; b++)
      if (mask[b]) res[8*b +: 8] = data[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/mailbox_timeout_ctr.sv
// mailbox_timeout_ctr: counts cycles while enabled, zeroed by i_clr.
// o_expire is asserted combinationally during the TIMEOUT-th enabled cycle
// after the last clear, so the owner can act on that same clock edge.
// Ports:
//   i_clk, i_rst (async, active-high)
//   i_en      - count this cycle
//   i_clr     - zero the counter (wins over i_en)
//   o_expire  - this is the TIMEOUT-th enabled cycle
module mailbox_timeout_ctr #(
  parameter int TIMEOUT = 50000,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expire
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                 r_cnt <= '0;
    else if (i_clr)            r_cnt <= '0;
    else if (i_en && !o_expire) r_cnt <= r_cnt + 1'b1;
  end

  // r_cnt holds the number of enabled cycles already elapsed.
  assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/tohost_mailbox.sv
// tohost_mailbox: HTIF-style tohost/fromhost mailbox.
// Snoops committed CPU stores to the tohost word, latches exit values
// (bit0=1) as a sticky exit, and forwards syscall values to the host. The
// host response is written back to FROMHOST_ADDR over a valid/ready port.
// Optional build macro: MAILBOX_TIMEOUT_EN - auto-respond with all-ones
// after TIMEOUT cycles pending and flag `timeout`.
// Ports:
//   clock, reset (async, active-high)
//   st_valid/st_addr/st_data/st_mask - committed store snoop
//   clear           - synchronous round restart
//   tohost, exit, exit_code          - mailbox word and exit status
//   req_valid, host_ack, host_resp   - host request/response
//   fromhost_w*                      - fromhost write port
//   overrun, timeout                 - sticky error flags
module tohost_mailbox
  import mailbox_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR   = ADDR_W'(MBOX_TOHOST_ADDR),
  parameter logic [ADDR_W-1:0] FROMHOST_ADDR = ADDR_W'(MBOX_FROMHOST_ADDR),
  parameter int                TIMEOUT       = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [63:0]       st_data,
  input  logic [7:0]        st_mask,
  input  logic              clear,
  output logic [63:0]       tohost,
  output logic              exit,
  output logic [62:0]       exit_code,
  output logic              req_valid,
  input  logic              host_ack,
  input  logic [63:0]       host_resp,
  output logic              fromhost_wvalid,
  input  logic              fromhost_wready,
  output logic [ADDR_W-1:0] fromhost_waddr,
  output logic [63:0]       fromhost_wdata,
  output logic              overrun,
  output logic              timeout
);

  mbox_state_e r_state, w_state_nxt;
  logic [63:0] r_tohost, w_tohost_nxt;
  logic [63:0] r_wdata, w_wdata_nxt;
  logic        r_overrun, w_overrun_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic        w_hit;
  logic        w_expire;
  logic [63:0] w_merged;
  logic        w_unused_addr_lo;

  // Only the 8-byte word index matters; byte offset is carried by st_mask.
  assign w_hit    = st_valid && (st_addr[ADDR_W-1:3] == TOHOST_ADDR[ADDR_W-1:3]) && (|st_mask);
  assign w_merged = mbox_merge(r_tohost, st_data, st_mask);
  assign w_unused_addr_lo = ^st_addr[2:0];

`ifdef MAILBOX_TIMEOUT_EN
  mailbox_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_en     (r_state == MBOX_PENDING),
    .i_clr    (clear || (r_state != MBOX_PENDING)),
    .o_expire (w_expire)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= MBOX_IDLE;
      r_tohost  <= '0;
      r_wdata   <= '0;
      r_overrun <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tohost  <= w_tohost_nxt;
      r_wdata   <= w_wdata_nxt;
      r_overrun <= w_overrun_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tohost_nxt  = r_tohost;
    w_wdata_nxt   = r_wdata;
    w_overrun_nxt = r_overrun;
    w_timeout_nxt = r_timeout;
    if (clear) begin
      // Round restart beats everything, including a same-cycle hit.
      w_state_nxt   = MBOX_IDLE;
      w_tohost_nxt  = '0;
      w_wdata_nxt   = '0;
      w_overrun_nxt = 1'b0;
      w_timeout_nxt = 1'b0;
    end else begin
      unique case (r_state)
        MBOX_IDLE: begin
          if (w_hit) begin
            w_tohost_nxt = w_merged;
            if (w_merged == '0)  w_state_nxt = MBOX_IDLE;
            else if (w_merged[0]) w_state_nxt = MBOX_DONE;
            else                  w_state_nxt = MBOX_PENDING;
          end
        end
        MBOX_PENDING: begin
          if (w_hit) w_overrun_nxt = 1'b1;
          // A real ack in the expiry cycle takes precedence.
          if (host_ack) begin
            w_wdata_nxt  = host_resp;
            w_tohost_nxt = '0;
            w_state_nxt  = MBOX_RESPOND;
          end else if (w_expire) begin
            w_wdata_nxt   = MBOX_TIMEOUT_RESP;
            w_tohost_nxt  = '0;
            w_timeout_nxt = 1'b1;
            w_state_nxt   = MBOX_RESPOND;
          end
        end
        MBOX_RESPOND: begin
          if (w_hit) w_overrun_nxt = 1'b1;
          if (fromhost_wready) w_state_nxt = MBOX_IDLE;
        end
        MBOX_DONE: ;  // sticky until clear/reset; hits ignored silently
        default: w_state_nxt = MBOX_IDLE;
      endcase
    end
  end

  assign tohost          = r_tohost;
  assign exit            = (r_state == MBOX_DONE);
  assign exit_code       = r_tohost[63:1];
  assign req_valid       = (r_state == MBOX_PENDING);
  assign fromhost_wvalid = (r_state == MBOX_RESPOND);
  assign fromhost_waddr  = FROMHOST_ADDR;
  assign fromhost_wdata  = r_wdata;
  assign overrun         = r_overrun;
  assign timeout         = r_timeout;

endmodule

// File: tb/tb_tohost_mailbox.sv
// tb_tohost_mailbox: directed + randomized bench for tohost_mailbox with a
// behavioural mailbox model checked against the DUT every cycle.
module tb_tohost_mailbox;

  localparam logic [31:0] TH = 32'h8000_1000;
  localparam logic [31:0] FH = 32'h8000_1040;
  localparam int          TO = 16;
`ifdef MAILBOX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = '0;
  logic [63:0] st_data = '0;
  logic [7:0]  st_mask = '0;
  logic        clear = 1'b0;
  logic        host_ack = 1'b0;
  logic [63:0] host_resp = '0;
  logic        fromhost_wready = 1'b0;
  logic [63:0] tohost;
  logic        exit;
  logic [62:0] exit_code;
  logic        req_valid;
  logic        fromhost_wvalid;
  logic [31:0] fromhost_waddr;
  logic [63:0] fromhost_wdata;
  logic        overrun;
  logic        timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tohost_mailbox #(.ADDR_W(32), .TOHOST_ADDR(TH), .FROMHOST_ADDR(FH), .TIMEOUT(TO)) dut (
    .clock(clk), .reset(rst), .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_mask(st_mask), .clear(clear), .tohost(tohost), .exit(exit), .exit_code(exit_code),
    .req_valid(req_valid), .host_ack(host_ack), .host_resp(host_resp),
    .fromhost_wvalid(fromhost_wvalid), .fromhost_wready(fromhost_wready),
    .fromhost_waddr(fromhost_waddr), .fromhost_wdata(fromhost_wdata),
    .overrun(overrun), .timeout(timeout));

  // ---------------- behavioural model ----------------
  // Phase of the mailbox conversation: nothing outstanding, waiting for the
  // host, writing the answer back, or the program has exited.
  localparam int P_IDLE = 0, P_HOST = 1, P_WRITE = 2, P_EXITED = 3;
  int          m_phase;
  logic [63:0] m_tohost, m_wdata;
  logic        m_overrun, m_timeout;
  int          m_waited;

  function automatic logic [63:0] byte_merge(input logic [63:0] o, input logic [63:0] d,
                                             input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = m[b] ? d[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  wire         m_hit    = st_valid && (st_addr[31:3] == TH[31:3]) && (st_mask != 8'h00);
  wire  [63:0] m_merged = byte_merge(m_tohost, st_data, st_mask);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= P_IDLE; m_tohost <= '0; m_wdata <= '0;
      m_overrun <= 1'b0; m_timeout <= 1'b0; m_waited <= 0;
    end else if (clear) begin
      m_phase <= P_IDLE; m_tohost <= '0; m_wdata <= '0;
      m_overrun <= 1'b0; m_timeout <= 1'b0; m_waited <= 0;
    end else if (m_phase == P_IDLE) begin
      if (m_hit) begin
        m_tohost <= m_merged;
        m_waited <= 0;
        if (m_merged == 64'h0)    m_phase <= P_IDLE;
        else if (m_merged[0])     m_phase <= P_EXITED;
        else                      m_phase <= P_HOST;
      end
    end else if (m_phase == P_HOST) begin
      if (m_hit) m_overrun <= 1'b1;
      if (host_ack) begin
        m_wdata <= host_resp; m_tohost <= '0; m_phase <= P_WRITE;
      end else if (TO_EN && (m_waited + 1 == TO)) begin
        m_wdata <= '1; m_tohost <= '0; m_timeout <= 1'b1; m_phase <= P_WRITE;
      end else begin
        m_waited <= m_waited + 1;
      end
    end else if (m_phase == P_WRITE) begin
      if (m_hit) m_overrun <= 1'b1;
      if (fromhost_wready) m_phase <= P_IDLE;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Single compare process: every cycle, DUT outputs vs the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("tohost",    tohost,          m_tohost);
      chk("exit",      64'(exit),       64'(m_phase == P_EXITED));
      chk("exit_code", 64'(exit_code),  64'(m_tohost[63:1]));
      chk("req_valid", 64'(req_valid),  64'(m_phase == P_HOST));
      chk("wvalid",    64'(fromhost_wvalid), 64'(m_phase == P_WRITE));
      chk("waddr",     64'(fromhost_waddr),  64'(FH));
      chk("wdata",     fromhost_wdata,  m_wdata);
      chk("overrun",   64'(overrun),    64'(m_overrun));
      chk("timeout",   64'(timeout),    64'(m_timeout));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(); @(negedge clk); endtask

  task automatic quiet();
    st_valid = 1'b0; st_mask = '0; clear = 1'b0; host_ack = 1'b0; fromhost_wready = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
    st_valid = 1'b1; st_addr = a; st_data = d; st_mask = m;
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); quiet();
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();
    // reset values
    chk("rst tohost", tohost, 64'h0);
    chk("rst waddr", 64'(fromhost_waddr), 64'h8000_1040);
    chk("rst flags", {59'h0, exit, req_valid, fromhost_wvalid, overrun, timeout}, 64'h0);

    // exit capture, then a further store is ignored without overrun
    store(TH, 64'h1, 8'hFF); tick(); quiet();
    chk("exit", 64'(exit), 64'h1);
    chk("exit tohost", tohost, 64'h1);
    chk("exit_code", 64'(exit_code), 64'h0);
    chk("exit req", 64'(req_valid), 64'h0);
    store(TH, 64'h3, 8'hFF); tick(); quiet();
    chk("done tohost", tohost, 64'h1);
    chk("done overrun", 64'(overrun), 64'h0);
    do_clear();
    chk("clear exit", 64'(exit), 64'h0);

    // syscall round trip
    store(TH, 64'h8000_2000, 8'hFF); tick(); quiet();
    chk("sys req", 64'(req_valid), 64'h1);
    tick(); tick();
    host_ack = 1'b1; host_resp = 64'h5; tick(); quiet();
    chk("sys wvalid", 64'(fromhost_wvalid), 64'h1);
    chk("sys wdata", fromhost_wdata, 64'h5);
    chk("sys waddr", 64'(fromhost_waddr), 64'h8000_1040);
    tick(); tick();
    chk("sys hold", {fromhost_wvalid, fromhost_wdata}, {1'b1, 64'h5});
    fromhost_wready = 1'b1; tick(); quiet();
    chk("sys idle", {62'h0, req_valid, fromhost_wvalid}, 64'h0);
    chk("sys tohost", tohost, 64'h0);

    // partial merge, then dropped store while pending
    store(TH, 64'h0000_0003_DEAD_BEEF, 8'hF0); tick(); quiet();
    chk("part tohost", tohost, 64'h0000_0003_0000_0000);
    chk("part req", 64'(req_valid), 64'h1);
    store(TH + 32'h4, 64'h1, 8'h0F); tick(); quiet();
    chk("part overrun", 64'(overrun), 64'h1);
    chk("part kept", tohost, 64'h0000_0003_0000_0000);
    do_clear();
    chk("clear overrun", 64'(overrun), 64'h0);

    // hit coinciding with clear is discarded
    store(TH, 64'h1, 8'hFF); clear = 1'b1; tick(); quiet();
    chk("prio tohost", tohost, 64'h0);
    chk("prio exit", 64'(exit), 64'h0);

    // reset mid-RESPOND drops wvalid before the next edge
    store(TH, 64'h2, 8'hFF); tick(); quiet();
    host_ack = 1'b1; host_resp = 64'h7; tick(); quiet();
    chk("pre-rst wvalid", 64'(fromhost_wvalid), 64'h1);
    #1 rst = 1'b1;
    #1 chk("async rst wvalid", 64'(fromhost_wvalid), 64'h0);
    #1 rst = 1'b0;
    tick();

`ifdef MAILBOX_TIMEOUT_EN
    store(TH, 64'h2, 8'hFF); tick(); quiet();
    repeat (TO - 1) tick();
    chk("to wait", {fromhost_wvalid, req_valid}, 64'h1);
    tick();
    chk("to wvalid", 64'(fromhost_wvalid), 64'h1);
    chk("to wdata", fromhost_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("to flag", 64'(timeout), 64'h1);
    fromhost_wready = 1'b1; tick(); quiet();
    do_clear();
    store(TH, 64'h2, 8'hFF); tick(); quiet();
    repeat (TO - 1) tick();
    host_ack = 1'b1; host_resp = 64'h9; tick(); quiet();
    chk("to ack flag", 64'(timeout), 64'h0);
    chk("to ack wdata", fromhost_wdata, 64'h9);
    fromhost_wready = 1'b1; tick(); quiet();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel = $urandom_range(0, 9);
      st_valid = ($urandom_range(0, 1) == 1);
      if (sel <= 5)      st_addr = {TH[31:3], 3'($urandom_range(0, 7))};
      else if (sel == 6) st_addr = FH;
      else               st_addr = $urandom;
      st_data = {$urandom, $urandom} & {8{($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00}};
      st_data[0] = ($urandom_range(0, 5) == 0);
      st_mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      clear = ($urandom_range(0, 39) == 0);
      host_ack = ($urandom_range(0, 3) == 0);
      host_resp = {$urandom, $urandom};
      fromhost_wready = ($urandom_range(0, 2) == 0);
      tick();
    end
    quiet();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tohost_mailbox.md
# tohost_mailbox

Synthesizable HTIF-style tohost/fromhost mailbox that snoops committed CPU stores and turns them into a host-facing request/exit interface. It is the writer end of the `tohost` word that the simulation harness polls for pass/fail and fuzz-round completion. It sits beside the memory model in the test harness:
- Exit values (bit0 set) are latched as a sticky `exit`.
- Syscall values (bit0 clear, nonzero) go to the host, and the host's response is written back to `FROMHOST_ADDR` through a valid/ready write port.

## Interface
Parameters:
- `ADDR_W`, 32, snooped store address width
- `TOHOST_ADDR`, 32'h8000_1000, 8-byte-aligned tohost location
- `FROMHOST_ADDR`, 32'h8000_1040, 8-byte-aligned fromhost location
- `TIMEOUT`, 50000, PENDING cycles before auto-response (only with `MAILBOX_TIMEOUT_EN`)

Ports:
- `clock` in 1: single clock; all logic on rising edge
- `reset` in 1: asynchronous, active-high
- `st_valid` in 1: committed store this cycle
- `st_addr` in ADDR_W: store address; bits [2:0] ignored
- `st_data` in 64: store data, lane-aligned
- `st_mask` in 8: byte enables
- `clear` in 1: synchronous round restart (fuzz loop)
- `tohost` out 64: merged tohost register
- `exit` out 1: sticky; tohost captured with bit0=1
- `exit_code` out 63: `tohost[63:1]`
- `req_valid` out 1: syscall pending to host
- `host_ack` in 1: host consumed request
- `host_resp` in 64: response value, sampled with `host_ack`
- `fromhost_wvalid` out 1: write request to memory model
- `fromhost_wready` in 1: memory model accepts write
- `fromhost_waddr` out ADDR_W: constant `FROMHOST_ADDR`
- `fromhost_wdata` out 64: response value
- `overrun` out 1: sticky; tohost store dropped
- `timeout` out 1: sticky; auto-response fired

## Operation
- **Tohost hit:** `st_valid`, `st_addr[ADDR_W-1:3]` equals `TOHOST_ADDR[ADDR_W-1:3]`, and `st_mask` is nonzero.
- **Merge:** each enabled byte of `st_data` replaces the same byte of the `tohost` register; disabled bytes keep their value.
- **States:** IDLE, PENDING, RESPOND, DONE. Reset state is IDLE.
- **IDLE:**
  - A hit performs the merge.
  - Merged value zero: stay IDLE.
  - Merged bit0 = 1: go to DONE.
  - Otherwise: go to PENDING.
- **PENDING:**
  - `req_valid`=1.
  - `host_ack`: latch `host_resp` into `fromhost_wdata`, zero `tohost`, go to RESPOND.
  - A hit in this state is dropped and sets `overrun`, including when it coincides with `host_ack`.
- **RESPOND:**
  - `fromhost_wvalid`=1, with `fromhost_wdata` held stable.
  - `fromhost_wready`: go to IDLE.
  - Hits are dropped and set `overrun`.
- **DONE:**
  - `exit`=1.
  - Hits are ignored and do not set `overrun`.
  - Only `clear` or `reset` leaves DONE.
- **clear:**
  - From any state: go to IDLE, zero `tohost` and `fromhost_wdata`, and clear `exit`, `overrun`, `timeout`.
  - Takes priority over every simultaneous event; a same-cycle hit is discarded.
- **Ignored traffic:** stores to `FROMHOST_ADDR` by the CPU have no effect.
- **Reset values:** all outputs 0 except `fromhost_waddr`, which is `FROMHOST_ADDR`.

## Timing
- Hit to `tohost`/`req_valid`/`exit`: 1 cycle (registered).
- `host_ack` to `fromhost_wvalid`: 1 cycle.
- `host_ack` is honoured only while `req_valid`=1; it is ignored in other states.
- `fromhost_wvalid` is held until `fromhost_wready`, with a same-cycle handshake.
- A hit is accepted in the first IDLE cycle after the handshake.
- `reset` mid-RESPOND drops `fromhost_wvalid` immediately (asynchronous clear); the write is lost by design.

## Configuration
- **`MAILBOX_TIMEOUT_EN` defined:**
  - A cycle counter runs in PENDING and is zeroed on entry.
  - When the counter reaches `TIMEOUT`, the block behaves as `host_ack` with `host_resp`=64'hFFFF_FFFF_FFFF_FFFF and sets `timeout`.
  - A real `host_ack` in the same cycle wins, and `timeout` stays 0.
- **Undefined:**
  - No counter; PENDING waits indefinitely.
  - `timeout` tied 0; `TIMEOUT` unused.

## Structure
- **Package `mailbox_pkg`:**
  - State enum `mbox_state_e`
  - Default `TOHOST_ADDR`/`FROMHOST_ADDR`
  - `MBOX_TIMEOUT_RESP` (all-ones)
- **Sub-module `mailbox_timeout_ctr`:** enable/clear/expire, width `$clog2(TIMEOUT+1)`, instantiated only under `MAILBOX_TIMEOUT_EN`.

## Test plan
- **Exit capture:** store 64'h1, mask 8'hFF, to `TOHOST_ADDR`.
  - Next cycle: `exit`=1, `tohost`=1, `exit_code`=0, `req_valid`=0.
  - A further store of 64'h3: `tohost` unchanged, `overrun`=0.
- **Syscall round-trip:** store 64'h8000_2000, giving `req_valid`=1.
  - `host_ack` with resp 64'h5 three cycles later: next cycle `fromhost_wvalid`=1, `fromhost_wdata`=5, `fromhost_waddr`=32'h8000_1040.
  - `fromhost_wready` low for 2 cycles then high: IDLE next cycle, `tohost`=0.
- **Partial merge:** mask 8'hF0 with data 64'h0000_0003_DEAD_BEEF.
  - `tohost`=64'h0000_0003_0000_0000, state PENDING.
  - Then mask 8'h0F with data 64'h0000_0000_0000_0001 while PENDING: dropped, `overrun`=1.
- **Priority:** a hit in the same cycle as `clear` gives `tohost`=0 and state IDLE.
  - `reset` pulsed mid-RESPOND: `fromhost_wvalid`=0 before the next clock edge.
- **Timeout (macro on, `TIMEOUT`=16):** store 64'h2 and never ack.
  - Exactly 16 PENDING cycles later: `fromhost_wvalid`=1, `fromhost_wdata`=all-ones, `timeout`=1.
  - Repeat with `host_ack` (resp 64'h9) on the 16th cycle: `timeout`=0, `fromhost_wdata`=64'h9.
